dma_read_engine: RTL and testbench

//  Consumer end of the CONFIG_VALID/CONFIG_READY command interface produced by the AXI config register slave.

---
 rtl/dma_read_engine.sv | 144 ++++++++++++++
 tb/tb_dma_read_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// Command-driven AXI3 read master: fetches CONFIG_LEN bytes from CONFIG_SRC in bursts
// that never cross 4KB, and streams each returned beat straight out on a valid/ready port.
module dma_read_engine #(
   parameter int          DATA_BYTES = 8,
   parameter int          MAX_BURST  = 16,
   parameter logic [11:0] AXI_ID     = 12'd0
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    CONFIG_VALID,
   output logic                    CONFIG_READY,
   input  logic [31:0]             CONFIG_CMD,
   input  logic [31:0]             CONFIG_SRC,
   input  logic [31:0]             CONFIG_LEN,
   output logic [31:0]             M_AXI_ARADDR,
   output logic [3:0]              M_AXI_ARLEN,
   output logic [2:0]              M_AXI_ARSIZE,
   output logic [1:0]              M_AXI_ARBURST,
   output logic [11:0]             M_AXI_ARID,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [8*DATA_BYTES-1:0] M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RLAST,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY,
   output logic [8*DATA_BYTES-1:0] OUT_DATA,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic                    ERR
);

   localparam int SIZE = $clog2(DATA_BYTES);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_addr;
   logic [31:0] r_beatsLeft;
   logic [4:0]  r_burstBeats;
   logic [4:0]  r_beatCnt;
   logic        r_err;

   logic [12:0] w_bytesToBoundary;
   logic [31:0] w_beatsToBoundary;
   logic [31:0] w_n32;
   logic [4:0]  w_n;
   logic        w_cmdFire;
   logic        w_startCmd;
   logic [31:0] w_cfgBeats;
   logic        w_beatFire;
   logic        w_finalBeat;
   logic [31:0] w_beatsLeftNext;
   logic        w_unused;

   assign w_unused = ^CONFIG_CMD[31:1];

   // Burst size is the smallest of the AXI3 cap, remaining beats and room left in the 4KB page.
   assign w_bytesToBoundary = 13'h1000 - {1'b0, r_addr[11:0]};
   assign w_beatsToBoundary = 32'(w_bytesToBoundary >> SIZE);

   always_comb begin
      w_n32 = 32'(MAX_BURST);
      if (r_beatsLeft < w_n32)       w_n32 = r_beatsLeft;
      if (w_beatsToBoundary < w_n32) w_n32 = w_beatsToBoundary;
   end

   assign w_n             = w_n32[4:0];
   assign w_cmdFire       = CONFIG_VALID && (r_state == IDLE);
   assign w_cfgBeats      = CONFIG_LEN >> SIZE;
   assign w_startCmd      = CONFIG_CMD[0] && (w_cfgBeats != 32'd0);
   assign w_beatFire      = (r_state == DATA) && M_AXI_RVALID && OUT_READY;
   assign w_finalBeat     = (r_beatCnt == 5'd1);
   assign w_beatsLeftNext = r_beatsLeft - 32'(r_burstBeats);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState   = r_state;
      CONFIG_READY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      OUT_VALID     = 1'b0;
      case (r_state)
         IDLE: begin
            CONFIG_READY = 1'b1;
            if (CONFIG_VALID && w_startCmd) w_nextState = ADDR;
         end
         ADDR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) w_nextState = DATA;
         end
         DATA: begin
            M_AXI_RREADY = OUT_READY;
            OUT_VALID    = M_AXI_RVALID;
            if (w_beatFire && w_finalBeat)
               w_nextState = (w_beatsLeftNext != 32'd0) ? ADDR : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Address/beat bookkeeping and sticky error; a bad beat is still counted toward burst completion.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_addr       <= 32'd0;
         r_beatsLeft  <= 32'd0;
         r_burstBeats <= 5'd0;
         r_beatCnt    <= 5'd0;
         r_err        <= 1'b0;
      end else begin
         if (w_cmdFire) begin
            r_addr      <= CONFIG_SRC & ~32'(DATA_BYTES - 1);
            r_beatsLeft <= w_cfgBeats;
            r_err       <= 1'b0;
         end
         if ((r_state == ADDR) && M_AXI_ARREADY) begin
            r_burstBeats <= w_n;
            r_beatCnt    <= w_n;
         end
         if (w_beatFire) begin
            r_beatCnt <= r_beatCnt - 5'd1;
            if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != w_finalBeat)) r_err <= 1'b1;
            if (w_finalBeat) begin
               r_addr      <= r_addr + (32'(r_burstBeats) << SIZE);
               r_beatsLeft <= w_beatsLeftNext;
            end
         end
      end
   end

   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARLEN   = 4'(w_n - 5'd1);
   assign M_AXI_ARSIZE  = 3'(SIZE);
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARID    = AXI_ID;
   assign OUT_DATA      = M_AXI_RDATA;
   assign ERR           = r_err;

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine: a hand-driven AXI slave and stream sink with
// per-scenario tasks comparing observed outputs against hand-computed values.
module tb_dma_read_engine;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        CONFIG_VALID;
   logic        CONFIG_READY;
   logic [31:0] CONFIG_CMD;
   logic [31:0] CONFIG_SRC;
   logic [31:0] CONFIG_LEN;
   logic [31:0] M_AXI_ARADDR;
   logic [3:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic [11:0] M_AXI_ARID;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY;
   logic [63:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RLAST;
   logic        M_AXI_RVALID;
   logic        M_AXI_RREADY;
   logic [63:0] OUT_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic        ERR;

   int nChecks = 0;
   int nPass   = 0;

   always #5 ACLK = ~ACLK;

   dma_read_engine #(.DATA_BYTES(8), .MAX_BURST(16), .AXI_ID(12'h5A3)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
      .CONFIG_CMD(CONFIG_CMD), .CONFIG_SRC(CONFIG_SRC), .CONFIG_LEN(CONFIG_LEN),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
      .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARID(M_AXI_ARID),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR(ERR)
   );

   // Stimulus tasks below are entered and left at 1ns after a rising edge.
   task automatic sendCmd(input logic [31:0] cmd, input logic [31:0] src, input logic [31:0] len,
                          output bit ok);
      int g;
      g  = 0;
      ok = 1'b0;
      while (!CONFIG_READY && g < 50) begin
         @(posedge ACLK); #1;
         g++;
      end
      if (CONFIG_READY) begin
         CONFIG_VALID = 1'b1;
         CONFIG_CMD   = cmd;
         CONFIG_SRC   = src;
         CONFIG_LEN   = len;
         @(posedge ACLK); #1;
         CONFIG_VALID = 1'b0;
         ok           = 1'b1;
      end
   endtask

   task automatic waitAr(input int delay, output bit found, output logic [31:0] addr,
                         output logic [3:0] len, output bit stable);
      found  = 1'b0;
      stable = 1'b1;
      addr   = '0;
      len    = '0;
      for (int g = 0; g < 50 && !found; g++) begin
         if (M_AXI_ARVALID) found = 1'b1;
         else begin @(posedge ACLK); #1; end
      end
      if (found) begin
         addr = M_AXI_ARADDR;
         len  = M_AXI_ARLEN;
         for (int d = 0; d < delay; d++) begin
            @(posedge ACLK); #1;
            if (!M_AXI_ARVALID || M_AXI_ARADDR !== addr || M_AXI_ARLEN !== len) stable = 1'b0;
         end
         M_AXI_ARREADY = 1'b1;
         @(posedge ACLK); #1;
         M_AXI_ARREADY = 1'b0;
      end
   endtask

   // Serves one R burst; bad counts cycles where the pass-through stream was wrong.
   task automatic rBurst(input int nBeats, input int errBeat, input int earlyLast, input bit toggle,
                         input logic [63:0] seed, output int bad, output bit done);
      int  sent;
      int  g;
      bit  phase;
      sent  = 0;
      g     = 0;
      phase = 1'b1;
      bad   = 0;
      while (sent < nBeats && g < 200) begin
         M_AXI_RVALID = 1'b1;
         M_AXI_RDATA  = seed + 64'(sent);
         M_AXI_RRESP  = (sent == errBeat) ? 2'b10 : 2'b00;
         M_AXI_RLAST  = (sent == nBeats - 1) || (sent == earlyLast);
         OUT_READY    = toggle ? phase : 1'b1;
         #1;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== M_AXI_RDATA || M_AXI_RREADY !== OUT_READY) bad++;
         @(posedge ACLK); #1;
         if (OUT_READY) sent++;
         phase = !phase;
         g++;
      end
      M_AXI_RVALID = 1'b0;
      M_AXI_RLAST  = 1'b0;
      M_AXI_RRESP  = 2'b00;
      OUT_READY    = 1'b1;
      done = (sent == nBeats);
   endtask

   task automatic test_reset();
      nChecks++;
      if (CONFIG_READY !== 1'b1 || M_AXI_ARVALID !== 1'b0)
         $display("[TB] FAIL reset_ready_arvalid: got ready=%b arvalid=%b expected ready=1 arvalid=0", CONFIG_READY, M_AXI_ARVALID);
      else nPass++;
      nChecks++;
      if (M_AXI_RREADY !== 1'b0 || OUT_VALID !== 1'b0 || ERR !== 1'b0)
         $display("[TB] FAIL reset_stream_err: got rready=%b ovalid=%b err=%b expected 0 0 0", M_AXI_RREADY, OUT_VALID, ERR);
      else nPass++;
   endtask

   task automatic test_single_burst();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      sendCmd(32'h1, 32'h1000, 32'd64, ok);
      waitAr(0, found, a, l, stable);
      nChecks++;
      if (!found || a !== 32'h1000 || l !== 4'd7)
         $display("[TB] FAIL t1_ar: got found=%b addr=%h len=%0d expected found=1 addr=00001000 len=7", found, a, l);
      else nPass++;
      nChecks++;
      if (M_AXI_ARSIZE !== 3'd3 || M_AXI_ARBURST !== 2'b01 || M_AXI_ARID !== 12'h5A3)
         $display("[TB] FAIL t1_ar_const: got size=%0d burst=%b id=%h expected 3 01 5a3", M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID);
      else nPass++;
      nChecks++;
      if (CONFIG_READY !== 1'b0 || M_AXI_ARVALID !== 1'b0)
         $display("[TB] FAIL t1_busy: got ready=%b arvalid=%b expected 0 0", CONFIG_READY, M_AXI_ARVALID);
      else nPass++;
      rBurst(8, -1, -1, 1'b0, 64'h1111_0000_0000_0000, bad, done);
      nChecks++;
      if (!done || bad !== 0)
         $display("[TB] FAIL t1_beats: got done=%b bad=%0d expected done=1 bad=0", done, bad);
      else nPass++;
      nChecks++;
      if (CONFIG_READY !== 1'b1 || M_AXI_ARVALID !== 1'b0 || ERR !== 1'b0)
         $display("[TB] FAIL t1_done: got ready=%b arvalid=%b err=%b expected 1 0 0", CONFIG_READY, M_AXI_ARVALID, ERR);
      else nPass++;
   endtask

   task automatic test_4k_split();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      sendCmd(32'h1, 32'h0FF0, 32'd64, ok);
      waitAr(0, found, a, l, stable);
      nChecks++;
      if (!found || a !== 32'h0FF0 || l !== 4'd1)
         $display("[TB] FAIL t2_ar1: got found=%b addr=%h len=%0d expected 1 00000ff0 1", found, a, l);
      else nPass++;
      rBurst(2, -1, -1, 1'b0, 64'h2222_0000_0000_0000, bad, done);
      waitAr(0, found, a, l, stable);
      nChecks++;
      if (!found || a !== 32'h1000 || l !== 4'd5)
         $display("[TB] FAIL t2_ar2: got found=%b addr=%h len=%0d expected 1 00001000 5", found, a, l);
      else nPass++;
      rBurst(6, -1, -1, 1'b0, 64'h2222_1000_0000_0000, bad, done);
      nChecks++;
      if (!done || bad !== 0 || CONFIG_READY !== 1'b1 || ERR !== 1'b0)
         $display("[TB] FAIL t2_done: got done=%b bad=%0d ready=%b err=%b expected 1 0 1 0", done, bad, CONFIG_READY, ERR);
      else nPass++;
   endtask

   task automatic test_multi_burst();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      logic [31:0] expAddr [3] = '{32'h2000, 32'h2080, 32'h2100};
      logic [3:0]  expLen  [3] = '{4'd15, 4'd15, 4'd4};
      sendCmd(32'h1, 32'h2000, 32'd300, ok);
      for (int b = 0; b < 3; b++) begin
         waitAr(0, found, a, l, stable);
         nChecks++;
         if (!found || a !== expAddr[b] || l !== expLen[b])
            $display("[TB] FAIL t3_ar%0d: got found=%b addr=%h len=%0d expected 1 %h %0d", b, found, a, l, expAddr[b], expLen[b]);
         else nPass++;
         rBurst(int'(expLen[b]) + 1, -1, -1, 1'b0, 64'h3333_0000_0000_0000 + 64'(b << 8), bad, done);
         nChecks++;
         if (!done || bad !== 0)
            $display("[TB] FAIL t3_beats%0d: got done=%b bad=%0d expected 1 0", b, done, bad);
         else nPass++;
      end
      nChecks++;
      if (CONFIG_READY !== 1'b1 || M_AXI_ARVALID !== 1'b0)
         $display("[TB] FAIL t3_done: got ready=%b arvalid=%b expected 1 0", CONFIG_READY, M_AXI_ARVALID);
      else nPass++;
   endtask

   task automatic test_no_start();
      bit ok;
      bit sawAr;
      logic [31:0] cmds [2] = '{32'h0, 32'h1};
      logic [31:0] lens [2] = '{32'd64, 32'd5};
      for (int k = 0; k < 2; k++) begin
         sendCmd(cmds[k], 32'h7000, lens[k], ok);
         nChecks++;
         if (!ok || CONFIG_READY !== 1'b1)
            $display("[TB] FAIL t4_ready%0d: got ok=%b ready=%b expected 1 1", k, ok, CONFIG_READY);
         else nPass++;
         sawAr = 1'b0;
         for (int c = 0; c < 5; c++) begin
            if (M_AXI_ARVALID) sawAr = 1'b1;
            @(posedge ACLK); #1;
         end
         nChecks++;
         if (sawAr !== 1'b0)
            $display("[TB] FAIL t4_noar%0d: got arvalid seen=%b expected 0", k, sawAr);
         else nPass++;
      end
   endtask

   task automatic test_back_to_back_backpressure();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      sendCmd(32'h1, 32'h3004, 32'd32, ok);
      waitAr(3, found, a, l, stable);
      nChecks++;
      if (!found || !stable || a !== 32'h3000 || l !== 4'd3)
         $display("[TB] FAIL t5_ar: got found=%b stable=%b addr=%h len=%0d expected 1 1 00003000 3", found, stable, a, l);
      else nPass++;
      rBurst(4, -1, -1, 1'b1, 64'h5555_0000_0000_0000, bad, done);
      nChecks++;
      if (!done || bad !== 0 || CONFIG_READY !== 1'b1 || ERR !== 1'b0)
         $display("[TB] FAIL t5_stream: got done=%b bad=%0d ready=%b err=%b expected 1 0 1 0", done, bad, CONFIG_READY, ERR);
      else nPass++;
   endtask

   task automatic test_errors();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      sendCmd(32'h1, 32'h4000, 32'd32, ok);
      waitAr(0, found, a, l, stable);
      rBurst(4, 1, -1, 1'b0, 64'h6666_0000_0000_0000, bad, done);
      nChecks++;
      if (!done || ERR !== 1'b1 || CONFIG_READY !== 1'b1)
         $display("[TB] FAIL t6_slverr: got done=%b err=%b ready=%b expected 1 1 1", done, ERR, CONFIG_READY);
      else nPass++;
      sendCmd(32'h1, 32'h4100, 32'd32, ok);
      nChecks++;
      if (ERR !== 1'b0)
         $display("[TB] FAIL t6_clear1: got err=%b expected 0", ERR);
      else nPass++;
      waitAr(0, found, a, l, stable);
      rBurst(4, -1, 2, 1'b0, 64'h6666_1000_0000_0000, bad, done);
      nChecks++;
      if (!done || bad !== 0 || ERR !== 1'b1 || CONFIG_READY !== 1'b1)
         $display("[TB] FAIL t6_rlast: got done=%b bad=%0d err=%b ready=%b expected 1 0 1 1", done, bad, ERR, CONFIG_READY);
      else nPass++;
      sendCmd(32'h0, 32'h0, 32'd0, ok);
      nChecks++;
      if (ERR !== 1'b0)
         $display("[TB] FAIL t6_clear2: got err=%b expected 0", ERR);
      else nPass++;
   endtask

   task automatic test_reset_mid();
      bit ok, found, stable, done;
      logic [31:0] a;
      logic [3:0]  l;
      int bad;
      sendCmd(32'h1, 32'h5000, 32'd64, ok);
      waitAr(0, found, a, l, stable);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 64'h7777;
      M_AXI_RRESP  = 2'b10;
      M_AXI_RLAST  = 1'b0;
      OUT_READY    = 1'b1;
      @(posedge ACLK); #1;
      nChecks++;
      if (ERR !== 1'b1 || OUT_VALID !== 1'b1)
         $display("[TB] FAIL t7_pre: got err=%b ovalid=%b expected 1 1", ERR, OUT_VALID);
      else nPass++;
      #2 ARESETN = 1'b0;
      #1;
      nChecks++;
      if (CONFIG_READY !== 1'b1 || OUT_VALID !== 1'b0 || M_AXI_RREADY !== 1'b0 ||
          M_AXI_ARVALID !== 1'b0 || ERR !== 1'b0)
         $display("[TB] FAIL t7_async: got ready=%b ovalid=%b rready=%b arvalid=%b err=%b expected 1 0 0 0 0",
                  CONFIG_READY, OUT_VALID, M_AXI_RREADY, M_AXI_ARVALID, ERR);
      else nPass++;
      M_AXI_RVALID = 1'b0;
      M_AXI_RRESP  = 2'b00;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      sendCmd(32'h1, 32'h6000, 32'd16, ok);
      waitAr(0, found, a, l, stable);
      nChecks++;
      if (!ok || !found || a !== 32'h6000 || l !== 4'd1)
         $display("[TB] FAIL t7_restart: got ok=%b found=%b addr=%h len=%0d expected 1 1 00006000 1", ok, found, a, l);
      else nPass++;
      rBurst(2, -1, -1, 1'b0, 64'h8888_0000_0000_0000, bad, done);
      nChecks++;
      if (!done || bad !== 0 || CONFIG_READY !== 1'b1 || ERR !== 1'b0)
         $display("[TB] FAIL t7_finish: got done=%b bad=%0d ready=%b err=%b expected 1 0 1 0", done, bad, CONFIG_READY, ERR);
      else nPass++;
   endtask

   initial begin
      ARESETN       = 1'b0;
      CONFIG_VALID  = 1'b0;
      CONFIG_CMD    = '0;
      CONFIG_SRC    = '0;
      CONFIG_LEN    = '0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RDATA   = '0;
      M_AXI_RRESP   = 2'b00;
      M_AXI_RLAST   = 1'b0;
      M_AXI_RVALID  = 1'b0;
      OUT_READY     = 1'b1;
      #12;
      test_reset();
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      test_single_burst();
      test_4k_split();
      test_multi_burst();
      test_no_start();
      test_back_to_back_backpressure();
      test_errors();
      test_reset_mid();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
